// File: rtl/input_debouncer.sv
// input_debouncer: two-channel synchroniser and debounce FSM front end
// producing clean levels, edge pulses and a saturating glitch count.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 16
) (
   input  logic Clock,
   input  logic Reset,
   input  logic sync_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic glitch
);
   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      PEND_HIGH   = 2'b01,
      STABLE_HIGH = 2'b10,
      PEND_LOW    = 2'b11
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

   state_t               state, state_nx;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx;
   logic                 level_nx, rise_nx, fall_nx;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= STABLE_LOW;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         level <= level_nx;
         rise  <= rise_nx;
         fall  <= fall_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      glitch   = 1'b0;
      case (state)
         STABLE_LOW: begin
            if (sync_in) begin
               state_nx = PEND_HIGH;
               cnt_nx   = ONE;
            end else begin
               cnt_nx = '0;
            end
         end
         PEND_HIGH: begin
            if (!sync_in) begin
               state_nx = STABLE_LOW;
               cnt_nx   = '0;
               glitch   = 1'b1;
            end else if (cnt == LAST) begin
               state_nx = STABLE_HIGH;
               cnt_nx   = '0;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         STABLE_HIGH: begin
            if (!sync_in) begin
               state_nx = PEND_LOW;
               cnt_nx   = ONE;
            end else begin
               cnt_nx = '0;
            end
         end
         PEND_LOW: begin
            if (sync_in) begin
               state_nx = STABLE_HIGH;
               cnt_nx   = '0;
               glitch   = 1'b1;
            end else if (cnt == LAST) begin
               state_nx = STABLE_LOW;
               cnt_nx   = '0;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         default: begin
            state_nx = STABLE_LOW;
            cnt_nx   = '0;
         end
      endcase
      // level follows the state being entered so it aligns with the pulses
      level_nx = (state_nx == STABLE_HIGH) || (state_nx == PEND_LOW);
   end
endmodule

module input_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       RawA,
   input  logic       RawB,
   output logic       A,
   output logic       B,
   output logic       ARise,
   output logic       AFall,
   output logic       BRise,
   output logic       BFall,
   output logic [7:0] GlitchCount
);
   logic [SYNC_STAGES-1:0] sync_a, sync_b;
   logic                   glitch_a, glitch_b;
   logic [8:0]             sum;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], RawA};
         sync_b <= {sync_b[SYNC_STAGES-2:0], RawB};
      end
   end

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH(CNT_WIDTH)
   ) u_chan_a (
      .Clock(Clock),
      .Reset(Reset),
      .sync_in(sync_a[SYNC_STAGES-1]),
      .level(A),
      .rise(ARise),
      .fall(AFall),
      .glitch(glitch_a)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH(CNT_WIDTH)
   ) u_chan_b (
      .Clock(Clock),
      .Reset(Reset),
      .sync_in(sync_b[SYNC_STAGES-1]),
      .level(B),
      .rise(BRise),
      .fall(BFall),
      .glitch(glitch_b)
   );

   // a joint abort may add 2, so saturate on the 9-bit sum
   assign sum = {1'b0, GlitchCount} + 9'(glitch_a) + 9'(glitch_b);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         GlitchCount <= '0;
      end else begin
         GlitchCount <= sum[8] ? 8'hFF : sum[7:0];
      end
   end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed and random stimulus checked every cycle
// against a sample-history model of the debouncer.
module tb_input_debouncer;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       RawA  = 1'b1;
   logic       RawB  = 1'b1;
   logic       A, B, ARise, AFall, BRise, BFall;
   logic [7:0] GlitchCount;

   int tests = 0;
   int fails = 0;

   input_debouncer #(
      .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_WIDTH(16)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .RawA(RawA),
      .RawB(RawB),
      .A(A),
      .B(B),
      .ARise(ARise),
      .AFall(AFall),
      .BRise(BRise),
      .BFall(BFall),
      .GlitchCount(GlitchCount)
   );

   always #5 Clock = ~Clock;

   // model: accepted level, run of samples differing from it, pulses
   bit m_lvl[2];
   int m_run[2];
   bit m_rise[2];
   bit m_fall[2];
   int m_gc;
   bit hist_a[$];
   bit hist_b[$];
   bit primed = 1'b0;

   always @(posedge Clock) begin
      int ab;
      bit s[2];
      if (Reset) begin
         for (int c = 0; c < 2; c++) begin
            m_lvl[c]  = 1'b0;
            m_run[c]  = 0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
         end
         m_gc = 0;
         hist_a.delete();
         hist_b.delete();
      end else begin
         ab   = 0;
         s[0] = (hist_a.size() >= SYNC) ? hist_a[SYNC-1] : 1'b0;
         s[1] = (hist_b.size() >= SYNC) ? hist_b[SYNC-1] : 1'b0;
         for (int c = 0; c < 2; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (s[c] == m_lvl[c]) begin
               if (m_run[c] > 0) ab++;
               m_run[c] = 0;
            end else begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_lvl[c]  = s[c];
                  m_rise[c] = s[c];
                  m_fall[c] = !s[c];
                  m_run[c]  = 0;
               end
            end
         end
         hist_a.push_front(RawA);
         hist_b.push_front(RawB);
         if (hist_a.size() > SYNC) void'(hist_a.pop_back());
         if (hist_b.size() > SYNC) void'(hist_b.pop_back());
         m_gc = (m_gc + ab > 255) ? 255 : m_gc + ab;
      end
      primed = 1'b1;
   end

   always @(negedge Clock) begin
      if (primed) begin
         logic [13:0] got, exp;
         got = {A, B, ARise, AFall, BRise, BFall, GlitchCount};
         exp = {m_lvl[0], m_lvl[1], m_rise[0], m_fall[0],
                m_rise[1], m_fall[1], 8'(m_gc)};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, got, exp);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic glitch_a(input bit both);
      RawA = 1'b1;
      if (both) RawB = 1'b1;
      cyc(2);
      RawA = 1'b0;
      RawB = 1'b0;
      cyc(2);
   endtask

   initial begin
      bit saw2;
      cyc(3);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_pulses", {ARise, AFall, BRise, BFall}, 0);
      chk("rst_gc", GlitchCount, 0);
      Reset = 1'b0;
      cyc(5);
      chk("rel_A_early", A, 0);
      cyc(1);
      chk("rel_A", A, 1);
      chk("rel_B", B, 1);
      chk("rel_ARise", ARise, 1);
      chk("rel_BRise", BRise, 1);
      cyc(1);
      chk("rel_ARise_1cyc", ARise, 0);

      RawA = 1'b0;
      RawB = 1'b0;
      cyc(10);
      RawA = 1'b1;
      cyc(5);
      chk("step_A_early", A, 0);
      cyc(1);
      chk("step_A", A, 1);
      chk("step_ARise", ARise, 1);
      RawA = 1'b0;
      cyc(5);
      chk("step_A_hold", A, 1);
      cyc(1);
      chk("step_AFall", AFall, 1);
      chk("step_A_low", A, 0);
      chk("step_gc", GlitchCount, 0);

      RawB = 1'b1;
      cyc(3);
      RawB = 1'b0;
      cyc(10);
      chk("g3_B", B, 0);
      chk("g3_gc", GlitchCount, 1);
      RawB = 1'b1;
      cyc(4);
      RawB = 1'b0;
      cyc(2);
      chk("g4_BRise", BRise, 1);
      cyc(3);
      chk("g4_B_hold", B, 1);
      cyc(1);
      chk("g4_BFall", BFall, 1);
      chk("g4_gc", GlitchCount, 1);

      saw2 = 1'b0;
      RawA = 1'b1;
      RawB = 1'b1;
      cyc(2);
      RawA = 1'b0;
      RawB = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (GlitchCount == 8'd2) saw2 = 1'b1;
      end
      chk("joint_gc", GlitchCount, 3);
      chk("joint_single_step", saw2, 0);

      for (int i = 0; i < 300; i++) glitch_a(1'b0);
      cyc(4);
      chk("sat_gc", GlitchCount, 255);
      glitch_a(1'b1);
      cyc(4);
      chk("sat_hold", GlitchCount, 255);

      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      for (int i = 0; i < 254; i++) glitch_a(1'b0);
      cyc(4);
      chk("pre_sat_gc", GlitchCount, 254);
      glitch_a(1'b1);
      cyc(4);
      chk("sat_254p2", GlitchCount, 255);

      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      RawA = 1'b1;
      cyc(3);
      Reset = 1'b1;
      cyc(1);
      chk("midrst_A", A, 0);
      chk("midrst_ARise", ARise, 0);
      chk("midrst_gc", GlitchCount, 0);
      Reset = 1'b0;
      cyc(5);
      chk("midrst_gc_after", GlitchCount, 0);
      cyc(1);
      chk("midrst_reaccept", A, 1);
      chk("midrst_reaccept_rise", ARise, 1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) RawA = ~RawA;
         if ($urandom_range(5) == 0) RawB = ~RawB;
         Reset = ($urandom_range(299) == 0);
         cyc(1);
      end
      Reset = 1'b0;
      cyc(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
